// File: rtl/mean_window_ctrl_if.sv
// Signal bundle between mean_window_ctrl, its sample source, mean_calc and the feature stage.
// master = the controller's view, slave = the surrounding datapath's view.
interface mean_window_ctrl_if #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 8
);
  logic                         enable;
  logic [ADDR_WIDTH-1:0]        window_len;
  logic                         sample_valid;
  logic signed [DATA_WIDTH-1:0] sample_data;
  logic                         sample_ready;
  logic                         mc_reset_n;
  logic                         mc_start;
  logic signed [DATA_WIDTH-1:0] mc_eeg;
  logic                         mc_start_div;
  logic                         mc_complete_div;
  logic signed [DATA_WIDTH-1:0] mc_mean;
  logic [ADDR_WIDTH-1:0]        mc_count;
  logic                         mean_valid;
  logic signed [DATA_WIDTH-1:0] mean_out;
  logic [ADDR_WIDTH-1:0]        mean_count;
  logic                         busy;
  logic                         err_timeout;

  modport master (
    input  enable, window_len, sample_valid, sample_data,
           mc_complete_div, mc_mean, mc_count,
    output sample_ready, mc_reset_n, mc_start, mc_eeg, mc_start_div,
           mean_valid, mean_out, mean_count, busy, err_timeout
  );

  modport slave (
    output enable, window_len, sample_valid, sample_data,
           mc_complete_div, mc_mean, mc_count,
    input  sample_ready, mc_reset_n, mc_start, mc_eeg, mc_start_div,
           mean_valid, mean_out, mean_count, busy, err_timeout
  );
endinterface

// File: rtl/mean_window_ctrl.sv
// Window sequencer for the mean_calc accumulate/divide datapath; all outputs registered.
// Optional divide watchdog enabled by defining MEAN_TIMEOUT_EN.
module mean_window_ctrl #(
  parameter int DATA_WIDTH  = 18,
  parameter int ADDR_WIDTH  = 8,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  mean_window_ctrl_if.master bus
);

  if (DIV_TIMEOUT < 1) begin : g_div_timeout_chk
    $error("DIV_TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_CLEAR,
    S_ACCUM,
    S_GAP,
    S_DIV_REQ,
    S_DIV_WAIT,
    S_DONE
  } state_t;

  state_t                       state, state_nxt;
  logic [ADDR_WIDTH-1:0]        scount, scount_nxt;
  logic [ADDR_WIDTH-1:0]        len, len_nxt;
  logic                         take;
  logic                         capture;

  logic                         ready_r;
  logic                         mc_reset_n_r;
  logic                         mc_start_r;
  logic signed [DATA_WIDTH-1:0] mc_eeg_r;
  logic                         mc_start_div_r;
  logic                         mean_valid_r;
  logic signed [DATA_WIDTH-1:0] mean_out_r;
  logic [ADDR_WIDTH-1:0]        mean_count_r;
  logic                         busy_r;

  // A zero-length window is meaningless, so it degenerates to a single sample.
  function automatic logic [ADDR_WIDTH-1:0] clamp_len(input logic [ADDR_WIDTH-1:0] l);
    return (l == '0) ? ADDR_WIDTH'(1) : l;
  endfunction

`ifdef MEAN_TIMEOUT_EN
  localparam int TMO_W = $clog2(DIV_TIMEOUT) + 1;

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_last;
  logic             expire;
  logic             err_r;

  assign tmo_last = (tmo_cnt == TMO_W'(DIV_TIMEOUT - 1));
`endif

  always_comb begin
    state_nxt  = state;
    scount_nxt = scount;
    len_nxt    = len;
    take       = 1'b0;
    capture    = 1'b0;
`ifdef MEAN_TIMEOUT_EN
    expire     = 1'b0;
`endif
    case (state)
      S_CLEAR: begin
        len_nxt    = clamp_len(bus.window_len);
        scount_nxt = '0;
        state_nxt  = S_ACCUM;
      end
      S_ACCUM: begin
        if (bus.sample_valid && ready_r) begin
          take       = 1'b1;
          scount_nxt = scount + 1'b1;
          state_nxt  = S_GAP;
        end
      end
      S_GAP: begin
        state_nxt = (scount == len) ? S_DIV_REQ : S_ACCUM;
      end
      S_DIV_REQ: begin
        state_nxt = S_DIV_WAIT;
      end
      S_DIV_WAIT: begin
        // Level-sensitive: a completion already high on entry is taken at once.
        if (bus.mc_complete_div) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end
`ifdef MEAN_TIMEOUT_EN
        else if (tmo_last) begin
          expire    = 1'b1;
          state_nxt = S_CLEAR;
        end
`endif
      end
      S_DONE: begin
        state_nxt = S_CLEAR;
      end
      default: begin
        state_nxt = S_CLEAR;
      end
    endcase
  end

  // Output registers are driven from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_CLEAR;
      scount         <= '0;
      len            <= '0;
      ready_r        <= 1'b0;
      mc_reset_n_r   <= 1'b0;
      mc_start_r     <= 1'b0;
      mc_eeg_r       <= '0;
      mc_start_div_r <= 1'b0;
      mean_valid_r   <= 1'b0;
      mean_out_r     <= '0;
      mean_count_r   <= '0;
      busy_r         <= 1'b0;
    end else begin
      state          <= state_nxt;
      scount         <= scount_nxt;
      len            <= len_nxt;
      ready_r        <= (state_nxt == S_ACCUM) && bus.enable;
      mc_reset_n_r   <= (state_nxt != S_CLEAR);
      mc_start_r     <= take;
      mc_start_div_r <= (state_nxt == S_DIV_REQ);
      mean_valid_r   <= (state_nxt == S_DONE);
      busy_r         <= !((state_nxt == S_ACCUM) && (scount_nxt == '0));
      if (take) begin
        mc_eeg_r <= bus.sample_data;
      end
      if (capture) begin
        mean_out_r   <= bus.mc_mean;
        mean_count_r <= bus.mc_count;
      end
    end
  end

`ifdef MEAN_TIMEOUT_EN
  // Counter indexes the cycles spent in DIV_WAIT; it sits at zero everywhere else.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt <= '0;
      err_r   <= 1'b0;
    end else begin
      err_r   <= expire;
      tmo_cnt <= (state == S_DIV_WAIT) ? tmo_cnt + 1'b1 : '0;
    end
  end

  assign bus.err_timeout = err_r;
`else
  assign bus.err_timeout = 1'b0;
`endif

  assign bus.sample_ready = ready_r;
  assign bus.mc_reset_n   = mc_reset_n_r;
  assign bus.mc_start     = mc_start_r;
  assign bus.mc_eeg       = mc_eeg_r;
  assign bus.mc_start_div = mc_start_div_r;
  assign bus.mean_valid   = mean_valid_r;
  assign bus.mean_out     = mean_out_r;
  assign bus.mean_count   = mean_count_r;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_mean_window_ctrl.sv
// Bench for mean_window_ctrl: emulated mean_calc, cycle-level reference model, directed + random windows.
`timescale 1ns/1ps
module tb_mean_window_ctrl;
  localparam int DW  = 18;
  localparam int AW  = 8;
  localparam int TMO = 64;
  localparam int PH_CLR = 0, PH_ACC = 1, PH_GAP = 2, PH_REQ = 3, PH_WAIT = 4, PH_DONE = 5;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mean_window_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mean_window_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIV_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- mean_calc emulation ----------------
  int acc = 0, cnt = 0, cd = -1, cmpl_delay = 1;
  always @(posedge clk) begin
    #1;
    bus.mc_complete_div = (cd == 0);
    if (cd >= 0) cd--;
    if (bus.mc_start_div === 1'b1) cd = (cmpl_delay < 0) ? -1 : cmpl_delay;
    if (bus.mc_reset_n !== 1'b1) begin
      acc = 0;
      cnt = 0;
    end else if (bus.mc_start === 1'b1) begin
      acc += int'(bus.mc_eeg);
      cnt++;
    end
    bus.mc_mean  = (cnt > 0) ? DW'(acc / cnt) : '0;
    bus.mc_count = AW'(cnt);
  end

  // ---------------- reference model ----------------
  int ph = PH_CLR, m_cnt = 0, m_len = 1, m_tw = 0;
  int m_q[$];
  logic e_ready = 0, e_rstn = 0, e_start = 0, e_div = 0, e_mv = 0, e_busy = 0, e_err = 0;
  logic signed [DW-1:0] e_eeg = '0, e_mean = '0;
  logic [AW-1:0] e_count = '0;

  function automatic void model_step();
    int nph;
    int sum;
    e_start = 1'b0;
    e_err   = 1'b0;
    if (reset) begin
      ph = PH_CLR; m_cnt = 0; m_q.delete();
      e_rstn = 0; e_ready = 0; e_div = 0; e_mv = 0; e_busy = 0;
      e_eeg = '0; e_mean = '0; e_count = '0;
      return;
    end
    nph = ph;
    case (ph)
      PH_CLR: begin
        m_len = (bus.window_len == '0) ? 1 : int'(bus.window_len);
        m_cnt = 0;
        m_q.delete();
        nph = PH_ACC;
      end
      PH_ACC: if (bus.sample_valid && e_ready) begin
        m_q.push_back(int'(bus.sample_data));
        m_cnt++;
        e_start = 1'b1;
        e_eeg   = bus.sample_data;
        nph     = PH_GAP;
      end
      PH_GAP:  nph = (m_cnt == m_len) ? PH_REQ : PH_ACC;
      PH_REQ: begin
        nph  = PH_WAIT;
        m_tw = 0;
      end
      PH_WAIT: begin
        if (bus.mc_complete_div) begin
          sum = 0;
          foreach (m_q[i]) sum += m_q[i];
          e_mean  = DW'(sum / m_len);
          e_count = AW'(m_len);
          nph     = PH_DONE;
        end else begin
`ifdef MEAN_TIMEOUT_EN
          if (m_tw == TMO - 1) begin
            e_err = 1'b1;
            nph   = PH_CLR;
          end
`endif
          m_tw++;
        end
      end
      default: nph = PH_CLR;
    endcase
    ph      = nph;
    e_rstn  = (ph != PH_CLR);
    e_ready = (ph == PH_ACC) && bus.enable;
    e_div   = (ph == PH_REQ);
    e_mv    = (ph == PH_DONE);
    e_busy  = !((ph == PH_ACC) && (m_cnt == 0));
  endfunction

  // ---------------- compare process ----------------
  bit   chk_on = 0;
  logic hs_n = 1'b0;
  int   cyc = 0, div_cyc = 0, err_cyc = 0;
  int   n_start = 0, n_div = 0, n_mv = 0, n_err = 0;
  int   hs_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (chk_on) begin
      check("sample_ready", bus.sample_ready, e_ready);
      check("mc_reset_n",   bus.mc_reset_n,   e_rstn);
      check("mc_start",     bus.mc_start,     e_start);
      check("mc_eeg",       $unsigned(bus.mc_eeg), $unsigned(e_eeg));
      check("mc_start_div", bus.mc_start_div, e_div);
      check("mean_valid",   bus.mean_valid,   e_mv);
      check("mean_out",     $unsigned(bus.mean_out), $unsigned(e_mean));
      check("mean_count",   bus.mean_count,   e_count);
      check("busy",         bus.busy,         e_busy);
      check("err_timeout",  bus.err_timeout,  e_err);
    end
    hs_n = bus.sample_valid & bus.sample_ready;
    if (hs_n === 1'b1) hs_cyc.push_back(cyc);
    if (bus.mc_start === 1'b1) n_start++;
    if (bus.mc_start_div === 1'b1) begin n_div++; div_cyc = cyc; end
    if (bus.mean_valid === 1'b1) n_mv++;
    if (bus.err_timeout === 1'b1) begin n_err++; err_cyc = cyc; end
    model_step();
    if (reset) chk_on = 1;
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] src_q[$];
  int idle_pct = 0;
  bit en_rand  = 0;

  task automatic step();
    @(posedge clk);
    #1;
    if (en_rand) bus.enable = ($urandom_range(99) >= 20);
    if (hs_n === 1'b1 && src_q.size() > 0) void'(src_q.pop_front());
    if (src_q.size() == 0) begin
      bus.sample_valid = 1'b0;
    end else begin
      if (hs_n === 1'b1 || !bus.sample_valid) bus.sample_valid = ($urandom_range(99) >= idle_pct);
      bus.sample_data = src_q[0];
    end
  endtask

  task automatic run_window(string nm, int bound);
    bit got = 0;
    for (int i = 0; i < bound && !got; i++) begin
      step();
      if (bus.mean_valid === 1'b1) got = 1;
    end
    check({nm, "_mean_valid_seen"}, got, 1);
  endtask

  task automatic wait_hs(string nm, int n);
    for (int i = 0; i < 200 && hs_cyc.size() < n; i++) step();
    check({nm, "_samples_taken"}, hs_cyc.size(), n);
  endtask

  initial begin
    int mv0, st0, rdy_hi, n0;
    logic [DW-1:0] keep_mean;
    bus.enable = 1'b1; bus.window_len = AW'(4);
    bus.sample_valid = 1'b0; bus.sample_data = '0;
    bus.mc_complete_div = 1'b0; bus.mc_mean = '0; bus.mc_count = '0;
    repeat (3) step();
    check("reset_mc_reset_n", bus.mc_reset_n, 0);
    check("reset_busy", bus.busy, 0);
    reset = 1'b0;

    // T1: known samples, mean 2.8125
    cmpl_delay = 2;
    st0 = n_start;
    src_q = '{18'h00800, 18'h02000, 18'h00400, 18'h08800};
    run_window("t1", 100);
    check("t1_mean_out", $unsigned(bus.mean_out), 32'h02D00);
    check("t1_mean_count", bus.mean_count, 4);
    check("t1_start_pulses", n_start - st0, 4);
    check("t1_div_pulses", n_div, 1);

    // T2: valid held continuously
    hs_cyc.delete();
    for (int i = 0; i < 4; i++) src_q.push_back(DW'($urandom));
    run_window("t2", 100);
    check("t2_hs_spacing_a", hs_cyc[1] - hs_cyc[0], 2);
    check("t2_hs_spacing_b", hs_cyc[3] - hs_cyc[2], 2);
    check("t2_div_after_last", div_cyc - hs_cyc[3], 2);

    // T3: reset after the second sample aborts the window
    hs_cyc.delete();
    for (int i = 0; i < 4; i++) src_q.push_back(DW'($urandom));
    wait_hs("t3", 2);
    reset = 1'b1; src_q.delete(); bus.sample_valid = 1'b0;
    mv0 = n_mv;
    step();
    reset = 1'b0;
    check("t3_rst_ready", bus.sample_ready, 0);
    check("t3_rst_mc_reset_n", bus.mc_reset_n, 0);
    check("t3_rst_mc_start", bus.mc_start, 0);
    check("t3_rst_mean_out", $unsigned(bus.mean_out), 0);
    check("t3_rst_mean_count", bus.mean_count, 0);
    repeat (20) step();
    check("t3_no_mean_valid", n_mv, mv0);
    for (int i = 0; i < 4; i++) src_q.push_back(DW'($urandom));
    run_window("t3_fresh", 100);
    check("t3_fresh_count", bus.mean_count, 4);

    // T4: zero length means one sample; mid-window length change is ignored
    bus.window_len = '0;
    src_q.push_back(18'h3F000);
    run_window("t4_len0", 100);
    check("t4_len0_mean", $unsigned(bus.mean_out), 32'h3F000);
    check("t4_len0_count", bus.mean_count, 1);
    bus.window_len = AW'(3);
    hs_cyc.delete();
    for (int i = 0; i < 3; i++) src_q.push_back(DW'($urandom));
    wait_hs("t4_mid", 1);
    bus.window_len = AW'(5);
    run_window("t4_mid", 100);
    check("t4_mid_count", bus.mean_count, 3);

    // T5: enable low for 10 cycles mid-window
    bus.window_len = AW'(6);
    hs_cyc.delete();
    for (int i = 0; i < 6; i++) src_q.push_back(DW'($urandom));
    wait_hs("t5", 2);
    bus.enable = 1'b0;
    rdy_hi = 0;
    n0 = hs_cyc.size();
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.sample_ready !== 1'b0) rdy_hi++;
    end
    check("t5_ready_low_cycles", rdy_hi, 0);
    check("t5_no_intake", hs_cyc.size(), n0);
    bus.enable = 1'b1;
    run_window("t5", 200);
    check("t5_count", bus.mean_count, 6);

`ifdef MEAN_TIMEOUT_EN
    // T6: divide watchdog
    bus.window_len = AW'(1);
    keep_mean = bus.mean_out;
    mv0 = n_mv; n0 = n_err;
    cmpl_delay = -1;
    src_q.push_back(DW'($urandom));
    for (int i = 0; i < 300 && n_err == n0; i++) step();
    check("t6_err_seen", n_err - n0, 1);
    check("t6_err_latency", err_cyc - div_cyc, TMO + 1);
    check("t6_mean_kept", $unsigned(bus.mean_out), $unsigned(keep_mean));
    check("t6_no_mean_valid", n_mv, mv0);
    cmpl_delay = TMO - 1;
    n0 = n_err;
    src_q.push_back(DW'($urandom));
    run_window("t6_late", 300);
    check("t6_late_no_err", n_err, n0);
    check("t6_late_count", bus.mean_count, 1);
`else
    keep_mean = '0;
`endif

    // Randomized windows
    en_rand = 1;
    for (int w = 0; w < 30; w++) begin
      int l;
      l = $urandom_range(0, 9);
      bus.window_len = AW'(l);
      idle_pct   = $urandom_range(0, 60);
      cmpl_delay = $urandom_range(0, 5);
      for (int i = 0; i < ((l == 0) ? 1 : l); i++) src_q.push_back(DW'($urandom));
      run_window("rand", 500);
    end
    en_rand = 0;
    bus.enable = 1'b1;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
